cpu_prog_loader: RTL and testbench

Program-memory writer for the 4-bit CPU: accepts a stream of 4-bit instruction words over a valid/ready handshake and writes them into an 8-entry program store. The CPU's program-counter read port fetches from that store. The block holds the CPU in a stopped state while a load is in progress and releases it once the full image has been written. It sits between the pad-level input pins and the CPU's instruction fetch, replacing the fixed ROM with a loadable one.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/prog_store.sv | 20 ++
 rtl/cpu_prog_loader.sv | 89 ++++++++
 tb/tb_cpu_prog_loader.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and loader FSM state for the 4-bit CPU
package cpu_pkg;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 3;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
endpackage

// File: rtl/prog_store.sv
// prog_store: DEPTH x DATA_W register file, sync write, comb read, sync clear
module prog_store #(
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/cpu_prog_loader.sv
// cpu_prog_loader: loads the CPU program store over valid/ready and gates cpu_run
// CPU_LOADER_CHECKSUM_EN adds a trailing checksum word and the err flag
module cpu_prog_loader #(
  parameter int DEPTH = 8,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CSUM = (ADDR_W+1)'(DEPTH);
  cpu_pkg::state_t state;
  logic accept, we;
  assign wr_ready = state == cpu_pkg::LOAD;
  assign busy = state == cpu_pkg::LOAD;
  assign cpu_run = state == cpu_pkg::RUN;
  // a restart request in the same cycle wins over the offered word
  assign accept = wr_ready && wr_valid && !load_req;
`ifdef CPU_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  assign we = accept && count != CSUM;
  always_ff @(posedge clk)
    if (rst) begin
      state <= cpu_pkg::IDLE;
      count <= '0;
      done <= 1'b0;
      err <= 1'b0;
      sum <= '0;
    end else begin
      done <= 1'b0;
      if (load_req) begin
        state <= cpu_pkg::LOAD;
        count <= '0;
        err <= 1'b0;
        sum <= '0;
      end else if (accept) begin
        count <= count + 1'b1;
        sum <= sum + wr_data;
        if (count == CSUM) begin
          state <= wr_data == sum ? cpu_pkg::RUN : cpu_pkg::IDLE;
          done <= wr_data == sum;
          err <= wr_data != sum;
        end
      end
    end
`else
  assign we = accept;
  assign err = 1'b0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= cpu_pkg::IDLE;
      count <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_req) begin
        state <= cpu_pkg::LOAD;
        count <= '0;
      end else if (accept) begin
        count <= count + 1'b1;
        if (count == LAST) begin
          state <= cpu_pkg::RUN;
          done <= 1'b1;
        end
      end
    end
`endif
  prog_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_store (
    .clk(clk),
    .rst(rst),
    .we(we),
    .wr_addr(count[ADDR_W-1:0]),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_cpu_prog_loader.sv
// tb_cpu_prog_loader: directed and random stimulus against a behavioural loader model
module tb_cpu_prog_loader;
`ifdef CPU_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int N = CK ? 9 : 8;
  logic clk = 1'b0, rst = 1'b0, load_req = 1'b0, wr_valid = 1'b0;
  logic [3:0] wr_data = '0, rd_data;
  logic [2:0] rd_addr = '0;
  logic wr_ready, cpu_run, busy, done, err;
  logic [3:0] count;
  int checks = 0, errs = 0;
  logic [3:0] m_mem [8];
  bit m_load, m_run, m_done, m_err;
  int m_cnt;

  always #20 clk = ~clk;

  cpu_prog_loader dut (
    .clk(clk), .rst(rst), .load_req(load_req), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_data(rd_data), .cpu_run(cpu_run),
    .busy(busy), .done(done), .count(count), .err(err)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] mem_sum();
    int s = 0;
    for (int i = 0; i < 8; i++) s += m_mem[i];
    return 4'(s);
  endfunction

  // one clock edge of the reference: what the spec says happens to the words and flags
  task automatic model_step(input logic lr, input logic v, input logic [3:0] d);
    m_done = 1'b0;
    if (lr) begin
      m_load = 1'b1; m_run = 1'b0; m_cnt = 0; m_err = 1'b0;
    end else if (m_load && v) begin
      if (m_cnt < 8) m_mem[m_cnt] = d;
      m_cnt++;
      if (m_cnt == N) begin
        m_load = 1'b0;
        if (!CK || d == mem_sum()) begin m_run = 1'b1; m_done = 1'b1; end
        else m_err = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check("cpu_run", 8'(cpu_run), 8'(m_run));
    check("busy", 8'(busy), 8'(m_load));
    check("wr_ready", 8'(wr_ready), 8'(m_load));
    check("done", 8'(done), 8'(m_done));
    check("count", 8'(count), 8'(m_cnt));
    check("err", 8'(err), 8'(m_err));
    rd_addr = 3'($urandom_range(7));
    #1 check("rd_data", 8'(rd_data), 8'(m_mem[rd_addr]));
  endtask

  task automatic read_all();
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      #1 check("rd_all", 8'(rd_data), 8'(m_mem[k]));
    end
  endtask

  task automatic cycle(input logic lr, input logic v, input logic [3:0] d);
    load_req = lr; wr_valid = v; wr_data = d;
    @(posedge clk);
    model_step(lr, v, d);
    #1 load_req = 1'b0; wr_valid = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_load = 0; m_run = 0; m_done = 0; m_err = 0; m_cnt = 0;
    #1 rst = 1'b0;
    check_outputs();
    read_all();
  endtask

  initial begin
    logic [3:0] s;
    int acc;
    do_reset();
    // back-to-back load of 1..8
    cycle(1, 0, 0);
    for (int k = 0; k < 8; k++) cycle(0, 1, 4'(k + 1));
    if (CK) cycle(0, 1, 4'h4);
    check("run_after_load", 8'(cpu_run), 8'd1);
    read_all();
    cycle(0, 0, 0);
    // gapped handshake
    cycle(1, 0, 0);
    acc = 0;
    for (int t = 0; t < 40 && m_load; t++) begin
      s = 4'($urandom);
      if (t % 2 == 1 && acc == 8 && CK) s = mem_sum();
      cycle(0, 1'(t % 2), s);
      if (t % 2 == 1) acc++;
    end
    check("gapped_done_accepts", 8'(acc), 8'(N));
    read_all();
    // restart mid-load with a word in the same cycle
    cycle(1, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 1, 4'(k + 7));
    cycle(1, 1, 4'hF);
    for (int k = 0; k < 8; k++) cycle(0, 1, 4'hA);
    if (CK) cycle(0, 1, 4'h0);
    read_all();
    // writes ignored in RUN, then reload drops cpu_run
    for (int k = 0; k < 3; k++) cycle(0, 1, 4'h5);
    read_all();
    cycle(1, 1, 4'h5);
    check("reload_drops_run", 8'(cpu_run), 8'd0);
    if (CK) begin
      for (int k = 0; k < 8; k++) cycle(0, 1, 4'($urandom));
      cycle(0, 1, mem_sum() + 4'd1);
      check("bad_csum_err", 8'(err), 8'd1);
      cycle(0, 1, 4'h3);
      read_all();
      cycle(1, 0, 0);
    end
    // random traffic
    for (int t = 0; t < 400; t++)
      cycle(1'($urandom_range(24) == 0), 1'($urandom_range(1)), 4'($urandom));
    // reset mid-load
    cycle(1, 0, 0);
    for (int k = 0; k < 5; k++) cycle(0, 1, 4'(k + 3));
    do_reset();
    check("busy_after_rst", 8'(busy), 8'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
